fc_psum_collector: RTL and testbench

FC_PSUM_COLLECTOR -- requirements
Module: fc_psum_collector

---
 rtl/fc_psum_collector.sv | 185 ++++++++++++++++++
 tb/tb_fc_psum_collector.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_psum_collector.sv
// Deskews the bottom-row psums of a systolic PE array, accumulates cfg_tiles
// aligned vectors per output row and queues each row result in a 2-entry FIFO.
module fc_psum_collector #(
   parameter int LANES = 4,
   parameter int PW    = 8,
   parameter int AW    = 16,
   parameter int TW    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [TW-1:0]       cfg_tiles,
   input  logic [TW-1:0]       cfg_rows,
   input  logic [LANES*PW-1:0] psum_i,
   input  logic                psum_vld_i,
   output logic [LANES*AW-1:0] out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o,
   output logic                ovf_o
);

   // Output handshake: a result transfers on a rising edge where out_valid_o and
   // out_ready_i are both high; out_valid_o and out_data_o hold until that edge.

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [TW-1:0] ONE = TW'(1);

   logic [PW-1:0]    al_lane [LANES];
   logic [LANES-2:0] vld_sr_q, vld_sr_d;
   logic             al_vld;

   // Lane k arrives k cycles after lane 0, so it needs LANES-1-k stages to line up.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      if (k == LANES-1) begin : g_direct
         assign al_lane[k] = psum_i[k*PW +: PW];
      end else begin : g_dly
         localparam int D = LANES-1-k;
         logic [PW-1:0] sr_q [D];
         logic [PW-1:0] sr_d [D];
         always_comb begin
            sr_d[0] = psum_i[k*PW +: PW];
            for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
         end
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int s = 0; s < D; s++) sr_q[s] <= '0;
            end else begin
               sr_q <= sr_d;
            end
         end
         assign al_lane[k] = sr_q[D-1];
      end
   end

   always_comb begin
      vld_sr_d[0] = psum_vld_i;
      for (int s = 1; s < LANES-1; s++) vld_sr_d[s] = vld_sr_q[s-1];
   end
   assign al_vld = vld_sr_q[LANES-2];

   state_t              state_q, state_d;
   logic [TW-1:0]       tiles_q, tiles_d, rows_q, rows_d;
   logic [TW-1:0]       tile_cnt_q, tile_cnt_d, row_cnt_q, row_cnt_d;
   logic [AW-1:0]       acc_q [LANES];
   logic [AW-1:0]       acc_d [LANES];
   logic [AW:0]         wide [LANES];
   logic [AW-1:0]       sum [LANES];
   logic [LANES*AW-1:0] push_data;
   logic                push, pop, full, drop, accept;
   logic                ovf_q, ovf_d;

   logic [LANES*AW-1:0] mem_q [2];
   logic [LANES*AW-1:0] mem_d [2];
   logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]          cnt_q, cnt_d;

   always_comb begin
      push_data = '0;
      for (int i = 0; i < LANES; i++) begin
         wide[i] = {1'b0, acc_q[i]} + (AW+1)'(al_lane[i]);
         sum[i]  = wide[i][AW] ? {AW{1'b1}} : wide[i][AW-1:0];
         push_data[i*AW +: AW] = sum[i];
      end
   end

   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign pop         = out_valid_o && out_ready_i;
   assign full        = (cnt_q == 2'd2);
   assign drop        = push && full && !pop;
   assign accept      = push && !drop;
   assign busy_o      = (state_q == RUN);
   assign ovf_o       = ovf_q;

   always_comb begin
      state_d    = state_q;
      tiles_d    = tiles_q;
      rows_d     = rows_q;
      tile_cnt_d = tile_cnt_q;
      row_cnt_d  = row_cnt_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               tiles_d    = (cfg_tiles == '0) ? ONE : cfg_tiles;
               rows_d     = (cfg_rows == '0) ? ONE : cfg_rows;
               tile_cnt_d = '0;
               row_cnt_d  = '0;
               ovf_d      = 1'b0;
               for (int i = 0; i < LANES; i++) acc_d[i] = '0;
            end
         end
         RUN: begin
            if (al_vld) begin
               if (tile_cnt_q == tiles_q - ONE) begin
                  push       = 1'b1;
                  tile_cnt_d = '0;
                  row_cnt_d  = row_cnt_q + ONE;
                  for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                  if (row_cnt_q == rows_q - ONE) state_d = IDLE;
               end else begin
                  tile_cnt_d = tile_cnt_q + ONE;
                  acc_d      = sum;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (drop) ovf_d = 1'b1;
   end

   // A push into a full FIFO with a same-edge pop overwrites the slot being popped.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (accept) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_sr_q   <= '0;
         state_q    <= IDLE;
         tiles_q    <= ONE;
         rows_q     <= ONE;
         tile_cnt_q <= '0;
         row_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
         for (int e = 0; e < 2; e++) mem_q[e] <= '0;
      end else begin
         vld_sr_q   <= vld_sr_d;
         state_q    <= state_d;
         tiles_q    <= tiles_d;
         rows_q     <= rows_d;
         tile_cnt_q <= tile_cnt_d;
         row_cnt_q  <= row_cnt_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_fc_psum_collector.sv
// Bench for fc_psum_collector: a 16-bit and a 9-bit accumulator instance share
// stimulus; results are predicted from per-row lane sums clipped to the width.
module tb_fc_psum_collector;
   localparam int LANES = 4;
   localparam int PW    = 8;
   localparam int AW    = 16;
   localparam int SAW   = 9;
   localparam int TW    = 4;

   logic                 clk = 1'b0;
   logic                 rst_n, start, psum_vld_i, out_ready_i;
   logic [TW-1:0]        cfg_tiles, cfg_rows;
   logic [LANES*PW-1:0]  psum_i;
   logic [LANES*AW-1:0]  out_data_o;
   logic                 out_valid_o, busy_o, ovf_o;
   logic [LANES*SAW-1:0] s_out_data_o;
   logic                 s_out_valid_o, s_busy_o, s_ovf_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic busy_hist [0:4095];
   logic vld_hist  [0:4095];

   logic [LANES*PW-1:0]  tx_q[$];
   logic [LANES*PW-1:0]  pass_vecs[$];
   logic [63:0]          got_q[$];
   logic [63:0]          exp_q[$];
   logic [63:0]          sat_got_q[$];
   logic [63:0]          sat_exp_q[$];

   fc_psum_collector #(.LANES(LANES), .PW(PW), .AW(AW), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_tiles(cfg_tiles), .cfg_rows(cfg_rows),
      .psum_i(psum_i), .psum_vld_i(psum_vld_i), .out_data_o(out_data_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o), .ovf_o(ovf_o)
   );

   fc_psum_collector #(.LANES(LANES), .PW(PW), .AW(SAW), .TW(TW)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_tiles(cfg_tiles), .cfg_rows(cfg_rows),
      .psum_i(psum_i), .psum_vld_i(psum_vld_i), .out_data_o(s_out_data_o),
      .out_valid_o(s_out_valid_o), .out_ready_i(out_ready_i), .busy_o(s_busy_o), .ovf_o(s_ovf_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: sample at the falling edge, return 1 time unit after the rising edge
   task automatic step();
      @(negedge clk);
      if (cyc < 4096) begin
         busy_hist[cyc] = busy_o;
         vld_hist[cyc]  = out_valid_o;
      end
      if (out_valid_o && out_ready_i) got_q.push_back(64'(out_data_o));
      if (s_out_valid_o && out_ready_i) sat_got_q.push_back(64'(s_out_data_o));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      psum_vld_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         psum_i = LANES*PW'($urandom);
         step();
      end
   endtask

   task automatic do_start(input int tiles, input int rows);
      cfg_tiles = TW'(tiles);
      cfg_rows  = TW'(rows);
      start     = 1'b1;
      step();
      start     = 1'b0;
      pass_vecs.delete();
   endtask

   // drive tx_q as skewed bottom-row traffic; pulse_c >= 0 raises out_ready_i in that cycle only
   task automatic drive_stream(input int pulse_c);
      int n;
      logic [LANES*PW-1:0] v;
      n = tx_q.size();
      for (int c = 0; c < n + LANES - 1; c++) begin
         psum_vld_i = (c < n);
         for (int k = 0; k < LANES; k++) begin
            if (c - k >= 0 && c - k < n) begin
               v = tx_q[c-k];
               psum_i[k*PW +: PW] = v[k*PW +: PW];
            end else begin
               psum_i[k*PW +: PW] = PW'($urandom);
            end
         end
         if (pulse_c >= 0) out_ready_i = (c == pulse_c);
         step();
      end
      psum_vld_i = 1'b0;
      foreach (tx_q[i]) pass_vecs.push_back(tx_q[i]);
      tx_q.delete();
      if (pulse_c >= 0) out_ready_i = 1'b0;
   endtask

   // reference: each row result is the plain lane-wise sum of its tiles, clipped to 2^W-1
   task automatic model_pass(input int tiles, input int rows);
      int t_eff, r_eff, s, idx;
      logic [LANES*PW-1:0] v;
      logic [63:0] e, se;
      t_eff = (tiles == 0) ? 1 : tiles;
      r_eff = (rows == 0) ? 1 : rows;
      for (int r = 0; r < r_eff; r++) begin
         e  = '0;
         se = '0;
         for (int k = 0; k < LANES; k++) begin
            s = 0;
            for (int t = 0; t < t_eff; t++) begin
               idx = r * t_eff + t;
               if (idx < pass_vecs.size()) begin
                  v = pass_vecs[idx];
                  s += int'(v[k*PW +: PW]);
               end
            end
            e[k*AW +: AW]   = (s > 65535) ? 16'hffff : 16'(s);
            se[k*SAW +: SAW] = (s > 511) ? 9'h1ff : 9'(s);
         end
         exp_q.push_back(e);
         sat_exp_q.push_back(se);
      end
   endtask

   task automatic compare_outputs(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) chk($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_sat_count"}, 64'(sat_got_q.size()), 64'(sat_exp_q.size()));
      for (int i = 0; i < sat_exp_q.size(); i++)
         if (i < sat_got_q.size()) chk($sformatf("%s_sat%0d", tag, i), sat_got_q[i], sat_exp_q[i]);
      got_q.delete();
      exp_q.delete();
      sat_got_q.delete();
      sat_exp_q.delete();
   endtask

   initial begin
      int t0, first, tiles, rows, n, chunk;
      rst_n = 1'b0; start = 1'b0; psum_vld_i = 1'b0; out_ready_i = 1'b1;
      cfg_tiles = '0; cfg_rows = '0; psum_i = '0;
      idle(3);
      rst_n = 1'b1;
      chk("rst_valid", 64'(out_valid_o), 64'(1'b0));
      chk("rst_data", 64'(out_data_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(1'b0));
      chk("rst_ovf", 64'(ovf_o), 64'(1'b0));
      got_q.delete(); sat_got_q.delete();

      // single tile, lanes 1..4, latency and busy fall
      do_start(1, 1);
      tx_q.push_back({8'd4, 8'd3, 8'd2, 8'd1});
      t0 = cyc;
      drive_stream(-1);
      idle(6);
      first = -1;
      for (int i = t0; i < t0 + 10; i++) if (first < 0 && vld_hist[i] === 1'b1) first = i;
      chk("single_latency", 64'(first), 64'(t0 + 4));
      chk("single_busy_before_push", 64'(busy_hist[t0+3]), 64'(1'b1));
      chk("single_busy_after_push", 64'(busy_hist[t0+4]), 64'(1'b0));
      if (got_q.size() > 0) chk("single_lanes", got_q[0], 64'h0004_0003_0002_0001);
      model_pass(1, 1);
      compare_outputs("single");

      // three tiles of 200 with a start pulse mid-pass that must be ignored
      do_start(3, 1);
      tx_q.push_back({4{8'd200}});
      drive_stream(-1);
      idle(3);
      chk("multi_none_after_t1", 64'(got_q.size()), 64'(0));
      cfg_tiles = TW'(1); start = 1'b1; step(); start = 1'b0; cfg_tiles = TW'(3);
      tx_q.push_back({4{8'd200}});
      drive_stream(-1);
      idle(3);
      chk("multi_none_after_t2", 64'(got_q.size()), 64'(0));
      tx_q.push_back({4{8'd200}});
      drive_stream(-1);
      idle(5);
      if (got_q.size() > 0) chk("multi_600", got_q[0], {4{16'd600}});
      model_pass(3, 1);
      compare_outputs("multi");

      // saturation: three tiles of 255 clip to 511 in the 9-bit instance
      do_start(3, 1);
      for (int i = 0; i < 3; i++) tx_q.push_back({4{8'd255}});
      drive_stream(-1);
      idle(5);
      if (sat_got_q.size() > 0) chk("sat_511", sat_got_q[0], 64'({4{9'h1ff}}));
      model_pass(3, 1);
      compare_outputs("sat");

      // backpressure: three rows, consumer stalled, third result dropped
      out_ready_i = 1'b0;
      do_start(1, 3);
      for (int i = 0; i < 3; i++) tx_q.push_back(LANES*PW'($urandom));
      drive_stream(-1);
      idle(3);
      model_pass(1, 3);
      chk("bp_valid", 64'(out_valid_o), 64'(1'b1));
      chk("bp_ovf", 64'(ovf_o), 64'(1'b1));
      chk("bp_head", 64'(out_data_o), exp_q[0]);
      idle(3);
      chk("bp_head_hold", 64'(out_data_o), exp_q[0]);
      out_ready_i = 1'b1;
      idle(4);
      void'(exp_q.pop_back());
      void'(sat_exp_q.pop_back());
      compare_outputs("bp");
      chk("bp_ovf_sticky", 64'(ovf_o), 64'(1'b1));

      // push into a full FIFO on the same edge as a pop
      out_ready_i = 1'b0;
      do_start(1, 3);
      chk("pp_ovf_cleared_by_start", 64'(ovf_o), 64'(1'b0));
      tx_q.push_back(LANES*PW'($urandom));
      drive_stream(-1);
      tx_q.push_back(LANES*PW'($urandom));
      drive_stream(-1);
      tx_q.push_back(LANES*PW'($urandom));
      drive_stream(LANES - 1);
      idle(3);
      chk("pp_ovf", 64'(ovf_o), 64'(1'b0));
      chk("pp_valid", 64'(out_valid_o), 64'(1'b1));
      out_ready_i = 1'b1;
      idle(4);
      model_pass(1, 3);
      compare_outputs("pp");

      // reset after tile 1 of 2, then a fresh single-tile pass
      do_start(2, 1);
      tx_q.push_back(LANES*PW'($urandom));
      drive_stream(-1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("rstmid_busy", 64'(busy_o), 64'(1'b0));
      chk("rstmid_valid", 64'(out_valid_o), 64'(1'b0));
      got_q.delete(); sat_got_q.delete();
      do_start(1, 1);
      tx_q.push_back(LANES*PW'($urandom));
      drive_stream(-1);
      idle(5);
      model_pass(1, 1);
      compare_outputs("rstmid");

      // random passes, including zero configs, chunked traffic with gaps
      for (int p = 0; p < 5; p++) begin
         tiles = (p == 0) ? 0 : $urandom_range(1, 3);
         rows  = (p == 1) ? 0 : $urandom_range(1, 3);
         do_start(tiles, rows);
         n = ((tiles == 0) ? 1 : tiles) * ((rows == 0) ? 1 : rows);
         while (n > 0) begin
            chunk = $urandom_range(1, 3);
            if (chunk > n) chunk = n;
            for (int i = 0; i < chunk; i++) tx_q.push_back(LANES*PW'($urandom));
            n -= chunk;
            drive_stream(-1);
            idle($urandom_range(0, 2));
         end
         idle(5);
         chk($sformatf("rand%0d_idle", p), 64'(busy_o), 64'(1'b0));
         model_pass(tiles, rows);
         compare_outputs($sformatf("rand%0d", p));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
